// File: rtl/fifo_lvl_ack.sv
`default_nettype none
// ============================================================================
// Module   : fifo_lvl_ack
// Purpose  : Single-clock FIFO with show-ahead or read-request output,
//            fill level, almost-full/empty flags, flush and sticky errors.
// Revision : 1.0  initial release
// ============================================================================
module fifo_lvl_ack #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int ACK_FIFO  = 1,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              enq,
    output logic              wrfull,
    output logic              almost_full,
    output logic [WIDTH-1:0]  data_out,
    input  logic              deq,
    output logic              rdempty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_af    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_ae    = (ADDR_W + 1)'(AE_THRESH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wrptr_q, wrptr_d;
    logic [ADDR_W:0]   rdptr_q, rdptr_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [ADDR_W:0]   level_w;
    logic              wr_acc, rd_acc;

    // Extra pointer MSB distinguishes full from empty; level is their difference.
    assign level_w      = wrptr_q - rdptr_q;
    assign level        = level_w;
    assign rdempty      = (level_w == '0);
    assign wrfull       = (level_w == c_depth);
    assign almost_full  = (level_w >= c_af);
    assign almost_empty = (level_w <= c_ae);
    assign data_out     = data_out_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_acc      = enq & ~wrfull & ~flush;
        rd_acc      = deq & ~rdempty & ~flush;
        wrptr_d     = wrptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rdptr_d     = rdptr_q + {{ADDR_W{1'b0}}, rd_acc};
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wrptr_d = '0;
            rdptr_d = '0;
        end
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (enq & wrfull & ~flush)  overflow_d  = 1'b1;
        if (deq & rdempty & ~flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wrptr_q[ADDR_W-1:0]] <= data_in;
    end

    generate
        if (ACK_FIFO != 0) begin : g_ack
            // Pre-fetch the next head; a word written into the slot being
            // fetched this cycle is forwarded straight from data_in.
            always_comb begin
                data_out_d = data_out_q;
                if (wrptr_d != rdptr_d) begin
                    if (wr_acc && (rdptr_d[ADDR_W-1:0] == wrptr_q[ADDR_W-1:0]))
                        data_out_d = data_in;
                    else
                        data_out_d = mem_q[rdptr_d[ADDR_W-1:0]];
                end
            end
        end else begin : g_req
            always_comb begin
                data_out_d = data_out_q;
                if (rd_acc) data_out_d = mem_q[rdptr_q[ADDR_W-1:0]];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr_q     <= '0;
            rdptr_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrptr_q     <= wrptr_d;
            rdptr_q     <= rdptr_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_lvl_ack.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_lvl_ack
// Purpose  : Directed + random bench for both output modes against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_lvl_ack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic             clk = 1'b0;
    logic             rst, flush, enq, deq, err_clr;
    logic [WIDTH-1:0] data_in;

    logic             a_wrfull, a_af, a_rdempty, a_ae, a_ov, a_un;
    logic [WIDTH-1:0] a_dout;
    logic [AW:0]      a_level;
    logic             r_wrfull, r_af, r_rdempty, r_ae, r_ov, r_un;
    logic [WIDTH-1:0] r_dout;
    logic [AW:0]      r_level;

    fifo_lvl_ack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACK_FIFO(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_ack (
        .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .enq(enq),
        .wrfull(a_wrfull), .almost_full(a_af), .data_out(a_dout), .deq(deq),
        .rdempty(a_rdempty), .almost_empty(a_ae), .level(a_level),
        .overflow(a_ov), .underflow(a_un), .err_clr(err_clr));

    fifo_lvl_ack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACK_FIFO(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_req (
        .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .enq(enq),
        .wrfull(r_wrfull), .almost_full(r_af), .data_out(r_dout), .deq(deq),
        .rdempty(r_rdempty), .almost_empty(r_ae), .level(r_level),
        .overflow(r_ov), .underflow(r_un), .err_clr(err_clr));

    always #5 clk = ~clk;

    logic [WIDTH-1:0] q[$];
    bit               m_ov, m_un;
    logic [WIDTH-1:0] m_dack, m_dreq;
    int               checks = 0;
    int               failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_un = 0; m_dack = '0; m_dreq = '0;
    endtask

    // Behavioural rules applied to the inputs seen at a rising edge.
    task automatic model_step();
        bit full, empty;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (err_clr) begin m_ov = 0; m_un = 0; end
        if (flush) begin
            q.delete();
        end else begin
            if (enq && full)  m_ov = 1;
            if (deq && empty) m_un = 1;
            if (deq && !empty) m_dreq = q.pop_front();
            if (enq && !full)  q.push_back(data_in);
        end
        if (q.size() > 0) m_dack = q[0];
    endtask

    task automatic check_all();
        int lv;
        lv = q.size();
        chk("ack_level",   32'(a_level),   32'(lv));
        chk("ack_rdempty", 32'(a_rdempty), 32'(lv == 0));
        chk("ack_wrfull",  32'(a_wrfull),  32'(lv == DEPTH));
        chk("ack_afull",   32'(a_af),      32'(lv >= AF));
        chk("ack_aempty",  32'(a_ae),      32'(lv <= AE));
        chk("ack_ovf",     32'(a_ov),      32'(m_ov));
        chk("ack_unf",     32'(a_un),      32'(m_un));
        chk("ack_dout",    32'(a_dout),    32'(m_dack));
        chk("req_level",   32'(r_level),   32'(lv));
        chk("req_flags",   {28'd0, r_wrfull, r_rdempty, r_af, r_ae},
                           {28'd0, 1'(lv == DEPTH), 1'(lv == 0), 1'(lv >= AF), 1'(lv <= AE)});
        chk("req_err",     {30'd0, r_ov, r_un}, {30'd0, m_ov, m_un});
        chk("req_dout",    32'(r_dout),    32'(m_dreq));
    endtask

    task automatic cyc(input bit e, input bit d, input logic [WIDTH-1:0] din,
                       input bit f = 0, input bit c = 0);
        enq = e; deq = d; data_in = din; flush = f; err_clr = c;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        enq = 0; deq = 0; flush = 0; err_clr = 0;
    endtask

    initial begin
        rst = 1; flush = 0; enq = 0; deq = 0; err_clr = 0; data_in = '0;
        model_reset();
        #1;
        check_all();
        #2 rst = 0;

        // Fill to full, overflow on the ninth write, then drain in order.
        for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
        chk("t1_full", 32'(a_wrfull), 32'd1);
        cyc(1, 0, 8'h99);
        chk("t1_ovf", 32'(a_ov), 32'd1);
        for (int i = 1; i <= 8; i++) cyc(0, 1, '0);
        cyc(0, 0, '0, 0, 1);

        // Show-ahead: word visible one cycle after the write into an empty FIFO.
        cyc(1, 0, 8'hA5);
        chk("t2_show_ahead", 32'(a_dout), 32'hA5);
        cyc(0, 1, '0);

        // Level 4 steady state with simultaneous read/write, pointers wrap.
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h10 + i));
        for (int i = 0; i < 20; i++) cyc(1, 1, 8'(8'h40 + i));
        chk("t3_level", 32'(a_level), 32'd4);

        // Threshold crossings: up to 6 then down to 1.
        cyc(1, 0, 8'h50);
        cyc(1, 0, 8'h51);
        chk("t4_afull", 32'(a_af), 32'd1);
        for (int i = 0; i < 5; i++) cyc(0, 1, '0);
        chk("t4_aempty", 32'(a_ae), 32'd1);
        cyc(0, 1, '0);

        // Underflow, then flush at level 5 with a concurrent write.
        cyc(0, 1, '0);
        chk("t6_unf", 32'(a_un), 32'd1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h60 + i));
        cyc(1, 1, 8'hEE, 1);
        chk("t5_flush_empty", 32'(a_rdempty), 32'd1);
        chk("t5_flags_kept", 32'(a_un), 32'd1);
        cyc(0, 0, '0, 0, 1);
        chk("t6_clr", 32'(a_un), 32'd0);

        // Random traffic with an asynchronous reset mid-burst.
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 9) == 0));
            if (n == 200) begin
                #2 rst = 1;
                #1;
                model_reset();
                check_all();
                rst = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
